crossing_request_scheduler: RTL and testbench

CROSSING_REQUEST_SCHEDULER -- requirements
Module: crossing_request_scheduler

---
 rtl/crossing_request_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_crossing_request_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossing_request_scheduler.sv
// Pedestrian crossing request scheduler: synchronizes and debounces four kerb
// buttons, latches pending requests and issues round-robin request pulses to
// the crossing controller, enforcing a minimum car-green time between crossings.
module crossing_request_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES      = 500000,
    parameter int unsigned MIN_GREEN_CYCLES     = 250000000,
    parameter int unsigned START_TIMEOUT_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       ped_green,
    output logic       ped_button_pressed,
    output logic [3:0] req_pending,
    output logic [1:0] served_id,
    output logic       busy,
    output logic       fault,
    output logic [7:0] req_count
);

    localparam int unsigned NB   = 4;
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned MG_W = $clog2(MIN_GREEN_CYCLES + 1);
    localparam int unsigned TO_W = $clog2(START_TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_MIN_GREEN,
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_END
    } state_e;

    logic [NB-1:0]   sync1_q, sync2_q;
    logic [NB-1:0]   deb_q, deb_d, deb_prev_q;
    logic [DB_W-1:0] db_cnt_q [NB];
    logic [DB_W-1:0] db_cnt_d [NB];
    logic [NB-1:0]   deb_rise;

    state_e          state_q, state_d;
    logic [MG_W-1:0] green_q, green_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      winner, cand;
    logic [NB-1:0]   pending_q, pending_d;
    logic [1:0]      served_q, served_d;
    logic            fault_q, fault_d;
    logic [7:0]      count_q, count_d;
    logic            pulse_q, busy_q;
    logic            pg_prev_q;
    logic            pg_rise, pg_fall, clear_pending;

    assign deb_rise = deb_q & ~deb_prev_q;
    assign pg_rise  = ped_green & ~pg_prev_q;
    assign pg_fall  = ~ped_green & pg_prev_q;

    // Per-bit debouncer: adopt the synchronized level after it disagrees long enough.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Synchronizer, debouncer and edge-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            pg_prev_q  <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            pg_prev_q  <= ped_green;
            for (int i = 0; i < NB; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // Round-robin pick: first pending bit at or after the pointer, wrapping.
    always_comb begin
        winner = rr_ptr_q;
        cand   = rr_ptr_q;
        for (int i = NB - 1; i >= 0; i--) begin
            cand = rr_ptr_q + 2'(i);
            if (pending_q[cand]) begin
                winner = cand;
            end
        end
    end

    // Next-state logic for the crossing sequence and its bookkeeping.
    always_comb begin
        state_d       = state_q;
        green_d       = green_q;
        to_d          = to_q;
        rr_ptr_d      = rr_ptr_q;
        served_d      = served_q;
        fault_d       = fault_q;
        count_d       = count_q;
        clear_pending = 1'b0;
        case (state_q)
            S_MIN_GREEN: begin
                if (green_q == MG_W'(MIN_GREEN_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    green_d = '0;
                end else begin
                    green_d = green_q + MG_W'(1);
                end
            end
            S_IDLE: begin
                if (|pending_q) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                served_d = winner;
                rr_ptr_d = winner + 2'd1;
                to_d     = '0;
                state_d  = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (pg_rise) begin
                    clear_pending = 1'b1;
                    count_d       = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    state_d       = S_WAIT_END;
                end else if (to_q == TO_W'(START_TIMEOUT_CYCLES - 1)) begin
                    fault_d = 1'b1;
                    green_d = '0;
                    state_d = S_MIN_GREEN;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WAIT_END: begin
                if (pg_fall) begin
                    green_d = '0;
                    state_d = S_MIN_GREEN;
                end
            end
            default: begin
                green_d = '0;
                state_d = S_MIN_GREEN;
            end
        endcase
        // A new press landing on the clearing cycle survives.
        pending_d = (clear_pending ? '0 : pending_q) | deb_rise;
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_MIN_GREEN;
            green_q   <= '0;
            to_q      <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            served_q  <= '0;
            fault_q   <= 1'b0;
            count_q   <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            green_q   <= green_d;
            to_q      <= to_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
            pulse_q   <= (state_d == S_ISSUE);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign ped_button_pressed = pulse_q;
    assign req_pending        = pending_q;
    assign served_id          = served_q;
    assign busy               = busy_q;
    assign fault              = fault_q;
    assign req_count          = count_q;

endmodule

// File: tb/tb_crossing_request_scheduler.sv
// Bench for crossing_request_scheduler with short timing parameters.
module tb_crossing_request_scheduler;

    localparam int unsigned D  = 4;
    localparam int unsigned MG = 10;
    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       ped_green;
    logic       ped_button_pressed;
    logic [3:0] req_pending;
    logic [1:0] served_id;
    logic       busy;
    logic       fault;
    logic [7:0] req_count;

    int total = 0;
    int bad   = 0;
    int exp_ptr;
    int exp_count;
    bit exp_fault;

    crossing_request_scheduler #(
        .DEBOUNCE_CYCLES(D),
        .MIN_GREEN_CYCLES(MG),
        .START_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .ped_green(ped_green),
        .ped_button_pressed(ped_button_pressed),
        .req_pending(req_pending),
        .served_id(served_id),
        .busy(busy),
        .fault(fault),
        .req_count(req_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Reference round-robin: first requested kerb at or after the pointer.
    function automatic int rr_pick(input logic [3:0] p, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (p[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return ptr;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IDLE with nothing pending: hold buttons D+4 cycles; pending appears
    // D+3 edges after the first sample, the request pulse one edge later.
    task automatic press_and_issue(input logic [3:0] press);
        btn_raw = press;
        for (int k = 1; k <= int'(D) + 4; k++) begin
            tick();
            total++;
            if (req_pending !== ((k >= int'(D) + 3) ? press : 4'b0000)) begin
                bad++;
                $display("FAIL press_pending k=%0d got=%b want=%b", k, req_pending,
                         (k >= int'(D) + 3) ? press : 4'b0000);
            end
            total++;
            if (ped_button_pressed !== (k == int'(D) + 4)) begin
                bad++;
                $display("FAIL press_pulse k=%0d got=%b want=%b", k, ped_button_pressed,
                         (k == int'(D) + 4));
            end
        end
        btn_raw = 4'b0000;
    endtask

    // Edge leaving ISSUE: served_id and pointer follow the round-robin rule.
    task automatic issue_check(input logic [3:0] pend);
        int w;
        w       = rr_pick(pend, exp_ptr);
        exp_ptr = (w + 1) % 4;
        tick();
        total++;
        if (served_id !== 2'(w) || ped_button_pressed !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL served got id=%0d pulse=%b busy=%b want id=%0d pulse=0 busy=1",
                     served_id, ped_button_pressed, busy, w);
        end
    endtask

    // Grant, green after a delay, green for len cycles, then full minimum green.
    task automatic finish_crossing(input logic [3:0] pend, input int delay, input int len);
        issue_check(pend);
        for (int i = 0; i < delay; i++) begin
            tick();
            total++;
            if (ped_button_pressed !== 1'b0 || fault !== exp_fault) begin
                bad++;
                $display("FAIL wait_start i=%0d got pulse=%b fault=%b want pulse=0 fault=%b",
                         i, ped_button_pressed, fault, exp_fault);
            end
        end
        ped_green = 1'b1;
        tick();
        exp_count = (exp_count == 255) ? 255 : exp_count + 1;
        total++;
        if (req_pending !== 4'b0000 || req_count !== 8'(exp_count)) begin
            bad++;
            $display("FAIL green_rise got pend=%b count=%0d want pend=0000 count=%0d",
                     req_pending, req_count, exp_count);
        end
        for (int i = 1; i < len; i++) begin
            tick();
            total++;
            if (busy !== 1'b1 || ped_button_pressed !== 1'b0) begin
                bad++;
                $display("FAIL wait_end i=%0d got busy=%b pulse=%b", i, busy, ped_button_pressed);
            end
        end
        ped_green = 1'b0;
        tick();
        for (int k = 1; k <= int'(MG); k++) begin
            tick();
            total++;
            if (busy !== (k < int'(MG)) || ped_button_pressed !== 1'b0) begin
                bad++;
                $display("FAIL min_green k=%0d got busy=%b pulse=%b want busy=%b pulse=0",
                         k, busy, ped_button_pressed, (k < int'(MG)));
            end
        end
    endtask

    // Grant with ped_green never rising: fault after TO cycles, re-issue after MG.
    task automatic timeout_crossing(input logic [3:0] pend);
        issue_check(pend);
        for (int k = 1; k <= int'(TO); k++) begin
            tick();
            total++;
            if (fault !== ((k == int'(TO)) ? 1'b1 : exp_fault) || ped_button_pressed !== 1'b0) begin
                bad++;
                $display("FAIL timeout k=%0d got fault=%b pulse=%b want fault=%b",
                         k, fault, ped_button_pressed, (k == int'(TO)) ? 1'b1 : exp_fault);
            end
        end
        exp_fault = 1'b1;
        total++;
        if (req_pending !== pend || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_keep got pend=%b busy=%b want pend=%b busy=1", req_pending, busy, pend);
        end
        for (int k = 1; k <= int'(MG) + 1; k++) begin
            tick();
            total++;
            if (ped_button_pressed !== (k == int'(MG) + 1) || busy !== (k != int'(MG))) begin
                bad++;
                $display("FAIL reissue k=%0d got pulse=%b busy=%b", k, ped_button_pressed, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_raw = 4'b0000; ped_green = 1'b0;
        exp_ptr = 0; exp_count = 0; exp_fault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ped_button_pressed, req_pending, served_id, busy, fault, req_count} !== 17'b0_0000_00_1_0_00000000) begin
            bad++;
            $display("FAIL reset_values got pulse=%b pend=%b id=%0d busy=%b fault=%b count=%0d",
                     ped_button_pressed, req_pending, served_id, busy, fault, req_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= int'(MG) + 2; k++) begin
            tick();
            total++;
            if (busy !== (k < int'(MG)) || ped_button_pressed !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy k=%0d got busy=%b pulse=%b want busy=%b",
                         k, busy, ped_button_pressed, (k < int'(MG)));
            end
        end
    endtask

    task automatic test_glitch();
        btn_raw = 4'b0100;
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) btn_raw = 4'b0000;
            tick();
            total++;
            if (req_pending !== 4'b0000 || ped_button_pressed !== 1'b0) begin
                bad++;
                $display("FAIL glitch k=%0d got pend=%b pulse=%b", k, req_pending, ped_button_pressed);
            end
        end
    endtask

    task automatic test_round_robin();
        press_and_issue(4'b1010);
        finish_crossing(4'b1010, 2, 5);
        press_and_issue(4'b1000);
        finish_crossing(4'b1000, 1, 5);
        press_and_issue(4'b1001);
        finish_crossing(4'b1001, 0, 2);
    endtask

    task automatic test_debounce_hold();
        press_and_issue(4'b0100);
        finish_crossing(4'b0100, 3, 5);
    endtask

    task automatic test_timeout();
        press_and_issue(4'b0011);
        timeout_crossing(4'b0011);
        finish_crossing(4'b0011, 4, 3);
    endtask

    // A debounced press landing on the ped_green rising edge survives the clear.
    task automatic test_set_wins();
        press_and_issue(4'b0001);
        issue_check(4'b0001);
        btn_raw = 4'b0100;
        for (int k = 1; k <= int'(D) + 2; k++) begin
            tick();
            total++;
            if (req_pending !== 4'b0001) begin
                bad++;
                $display("FAIL set_wins_pre k=%0d got=%b want=0001", k, req_pending);
            end
        end
        ped_green = 1'b1;
        tick();
        exp_count = (exp_count == 255) ? 255 : exp_count + 1;
        total++;
        if (req_pending !== 4'b0100 || req_count !== 8'(exp_count)) begin
            bad++;
            $display("FAIL set_wins got pend=%b count=%0d want pend=0100 count=%0d",
                     req_pending, req_count, exp_count);
        end
        tick();
        btn_raw = 4'b0000;
        ped_green = 1'b0;
        tick();
        for (int k = 1; k <= int'(MG) + 1; k++) begin
            tick();
            total++;
            if (ped_button_pressed !== (k == int'(MG) + 1)) begin
                bad++;
                $display("FAIL set_wins_issue k=%0d got pulse=%b", k, ped_button_pressed);
            end
        end
        finish_crossing(4'b0100, 1, 2);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [3:0] press;
            press = 4'($urandom_range(1, 15));
            press_and_issue(press);
            if ($urandom_range(0, 3) == 0) timeout_crossing(press);
            finish_crossing(press, int'($urandom_range(0, 12)), int'($urandom_range(1, 6)));
        end
    endtask

    task automatic test_saturation();
        for (int it = 0; it < 260; it++) begin
            press_and_issue(4'b0001 << (it % 4));
            finish_crossing(4'b0001 << (it % 4), 0, 1);
        end
        total++;
        if (req_count !== 8'd255) begin
            bad++;
            $display("FAIL saturation got=%0d want=255", req_count);
        end
    endtask

    // Reset in WAIT_END with a button held through it: outputs clear at once,
    // and the held button is taken as a fresh press after release.
    task automatic test_reset_mid_wait_end();
        press_and_issue(4'b1000);
        issue_check(4'b1000);
        ped_green = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        btn_raw = 4'b0010;
        ped_green = 1'b0;
        #1;
        total++;
        if ({ped_button_pressed, req_pending, served_id, busy, fault, req_count} !== 17'b0_0000_00_1_0_00000000) begin
            bad++;
            $display("FAIL reset_mid got pulse=%b pend=%b id=%0d busy=%b fault=%b count=%0d",
                     ped_button_pressed, req_pending, served_id, busy, fault, req_count);
        end
        exp_ptr = 0; exp_count = 0; exp_fault = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= int'(MG) + 1; k++) begin
            tick();
            if (k == int'(D) + 4) btn_raw = 4'b0000;
            total++;
            if (req_pending !== ((k >= int'(D) + 3) ? 4'b0010 : 4'b0000) ||
                ped_button_pressed !== (k == int'(MG) + 1)) begin
                bad++;
                $display("FAIL held_after_reset k=%0d got pend=%b pulse=%b", k, req_pending, ped_button_pressed);
            end
        end
        finish_crossing(4'b0010, 2, 3);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_round_robin();
        test_debounce_hold();
        test_timeout();
        test_set_wins();
        test_random();
        test_saturation();
        test_reset_mid_wait_end();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
